status_flag_unit: RTL
=====================

Name: status_flag_unit

Overview:
- Architectural NZCV status register feeding the ID-stage condition checker, with flag-hazard tracking.
- Holds flags written back from EXE and tracks in-flight flag-setting (S-bit) instructions between ID and flag write.
- Stalls ID when a conditional instruction would read stale flags.
- Provides a one-entry shadow copy for exception save/restore.

Parameters:
- FLAG_LAT, 2, pipeline advances from ID issue to flag write (1..4).
- RESET_FLAGS, 4'b0000, status value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a valid instruction
- id_cond  input  4  ID condition field; 4'b1110 (AL) and 4'b1111 read no flags
- id_s  input  1  ID instruction sets flags
- flush  input  1  squash all in-flight instructions younger than writeback
- flag_wr  input  1  EXE flag write strobe (valid S-instruction completing)
- flag_in  input  4  new flags: [3]=Z, [2]=C, [1]=V, [0]=N
- save  input  1  copy status to shadow
- restore  input  1  copy shadow to status
- status  output  4  flags to condition checker, same bit order as flag_in
- stall_id  output  1  hold ID/IF this cycle
- pending  output  3  count of in-flight flag writers (0..FLAG_LAT)
- err_underflow  output  1  sticky: flag_wr seen with no tracked writer

Behaviour:
- Reset (rst=1 at clk edge): status=RESET_FLAGS, shadow=RESET_FLAGS, pending shift register cleared, pending=0, err_underflow=0. stall_id is combinational and low while pending=0.
- Tracking: FLAG_LAT-bit shift register sreg. Each edge, sreg shifts one position toward writeback. The new entry is id_valid & id_s & ~stall_id & ~flush; sreg[0] is the newest entry.
- pending = popcount(sreg), zero-extended to 3 bits.
- stall_id = id_valid & (id_cond<4'b1110) & (pending!=0). When stalled, a bubble (0) enters sreg.
- Stall rule is independent of id_s: an S-instruction that reads no flags never stalls.
- Flag write: on an edge with flag_wr=1, status<=flag_in. The oldest sreg bit retires regardless of flag_wr.
- If flag_wr=1 while the retiring bit is 0, err_underflow<=1 (sticky until reset) and status is still written.
- flush: clears all sreg bits except the retiring one. The same-cycle flag_wr still commits. The same-cycle ID instruction does not enter sreg.
- save: shadow<=status. If flag_wr occurs in the same cycle, shadow takes the pre-write status.
- restore: status<=shadow and takes priority over flag_wr in the same cycle. sreg is unaffected.
- save and restore together: both occur; shadow gets the old status, status gets the old shadow (swap).
- status changes only at clock edges; no combinational path from flag_in without the optional feature.
- Latency: a flag-setting instruction issued at edge k writes at edge k+FLAG_LAT. A dependent conditional instruction is released in the cycle after that write.
- Width rules: pending saturates logically at FLAG_LAT; FLAG_LAT>4 is illegal (elaboration error).

Optional Feature:
- FLAG_BYPASS_EN defined:
  - status = flag_wr ? flag_in : stored flags (restore still overrides, giving shadow).
  - The stall condition uses pending excluding the retiring bit when flag_wr=1.
  - A dependent instruction proceeds in the write cycle, saving one stall cycle.
- FLAG_BYPASS_EN undefined: registered-only behaviour as above.

Test Plan:
1. Reset with RESET_FLAGS=0 -> status=0000, pending=0, stall_id=0, err_underflow=0. Then flag_wr=1, flag_in=1000 -> status=1000 next cycle.
2. FLAG_LAT=2: issue id_s=1 (AL) at cycle 0, then id_cond=0000 (EQ) at cycle 1 -> stall_id=1 for cycles 1-2 (flag_wr at edge 2, flag_in=1000), released cycle 3 with status=1000. With FLAG_BYPASS_EN, stall is cycle 1 only.
3. Pending writer plus id_cond=1110 -> stall_id=0. An S-instruction with id_cond=1110 issued back-to-back -> pending=2.
4. Two writers in flight, flush=1 -> pending becomes 0 after the retiring entry. A later flag_wr -> err_underflow=1.
5. status=0101, save, then flag_wr 0010, then restore -> status 0101. Simultaneous restore and flag_wr=1111 -> status=shadow.
6. save+restore same cycle with status=0001, shadow=1100 -> status=1100, shadow=0001.

Source files
------------

// File: rtl/status_flag_unit.sv
// status_flag_unit: architectural NZCV status register with in-flight S-bit hazard tracking and a one-entry shadow.
// Optional macro FLAG_BYPASS_EN forwards flag_in onto status in the write cycle and releases dependents one cycle earlier.
module status_flag_unit #(
  parameter int unsigned FLAG_LAT    = 2,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       flush,
  input  logic       flag_wr,
  input  logic [3:0] flag_in,
  input  logic       save,
  input  logic       restore,
  output logic [3:0] status,
  output logic       stall_id,
  output logic [2:0] pending,
  output logic       err_underflow
);

  if (FLAG_LAT < 1 || FLAG_LAT > 4) begin : g_bad_flag_lat
    $error("status_flag_unit: FLAG_LAT must be in the range 1..4");
  end

  logic [FLAG_LAT-1:0] sreg_q, sreg_d;
  logic [3:0]          status_q, status_d;
  logic [3:0]          shadow_q, shadow_d;
  logic                err_q, err_d;
  logic                retiring;
  logic                reads_flags;
  logic                new_entry;
  logic [2:0]          pend_all;
  logic [2:0]          pend_eff;

  assign retiring    = sreg_q[FLAG_LAT-1];
  assign reads_flags = (id_cond < 4'b1110);

  always_comb begin
    pend_all = 3'd0;
    for (int i = 0; i < FLAG_LAT; i++) begin
      pend_all = pend_all + {2'b00, sreg_q[i]};
    end
  end

  // With bypass, the writer retiring this cycle already supplies its flags, so it no longer blocks readers.
`ifdef FLAG_BYPASS_EN
  assign pend_eff = pend_all - {2'b00, flag_wr & retiring};
`else
  assign pend_eff = pend_all;
`endif

  assign stall_id  = id_valid & reads_flags & (pend_eff != 3'd0);
  assign new_entry = id_valid & id_s & ~stall_id & ~flush;

  // A flush drops every younger writer; only the retiring slot survives, and it leaves this edge anyway.
  always_comb begin
    sreg_d = '0;
    if (!flush) begin
      for (int i = FLAG_LAT - 1; i > 0; i--) begin
        sreg_d[i] = sreg_q[i-1];
      end
      sreg_d[0] = new_entry;
    end
  end

  always_comb begin
    status_d = status_q;
    if (restore) begin
      status_d = shadow_q;
    end else if (flag_wr) begin
      status_d = flag_in;
    end
    shadow_d = save ? status_q : shadow_q;
    err_d    = err_q | (flag_wr & ~retiring);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q   <= '0;
      status_q <= RESET_FLAGS;
      shadow_q <= RESET_FLAGS;
      err_q    <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      status_q <= status_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  always_comb begin
    status = status_q;
    if (restore) begin
      status = shadow_q;
    end else if (flag_wr) begin
      status = flag_in;
    end
  end
`else
  assign status = status_q;
`endif

  assign pending       = pend_all;
  assign err_underflow = err_q;

endmodule
